float_root_class_buffer: RTL
============================

// Module: float_root_class_buffer
// PURPOSE
// - Downstream consumer of the float discriminant stage (b^2 - 4ac).
// - Classifies each discriminant result as: no real roots, one root, two roots, or error.
// - Buffers {disc, class} in a small FIFO and hands entries out on a valid/ready port.
// - Needed because the discriminant stage has no backpressure: this block absorbs
//   results, flags overflow and keeps per-class counts for debug.
// PARAMETERS
// - FLEN    64  float width (IEEE-754 double); matches the codebase-wide FLEN
// - DEPTH    4  FIFO entries; power of two, >= 2
// - CNT_W   16  width of each per-class statistics counter
// PORTS
// - clk            in   1         clock; all state updates on its rising edge
// - rst            in   1         reset, asynchronous, active-low
// - disc_vld       in   1         one-cycle strobe: disc/disc_err valid
// - disc           in   FLEN      discriminant value
// - disc_err       in   1         upstream arithmetic error for this result
// - out_vld        out  1         FIFO head valid
// - out_rdy        in   1         consumer accepts head when out_vld & out_rdy
// - out_disc       out  FLEN      head discriminant
// - out_class      out  2         head class (root_class_t)
// - full           out  1         count == DEPTH
// - overflow       out  1         sticky: a result was dropped
// - clr            in   1         sync clear of overflow and all counters (FIFO untouched)
// - cnt_none       out  CNT_W     saturating count of NO_REAL pushes
// - cnt_one        out  CNT_W     saturating count of ONE_ROOT pushes
// - cnt_two        out  CNT_W     saturating count of TWO_ROOTS pushes
// - cnt_err        out  CNT_W     saturating count of ERR pushes
// BEHAVIOUR
// - Reset (rst=0, async): FIFO empty (count=0, pointers=0), out_vld=0, overflow=0,
//   all counters=0. out_disc/out_class are don't-care while out_vld=0.
// - Classification, combinational on the inputs, in priority order:
//   - disc_err=1                                  -> ERR
//   - disc is NaN (exp all-ones, mantissa != 0)   -> ERR
//   - exp==0 && mantissa==0 (+0 or -0)            -> ONE_ROOT
//   - sign=1 (incl. -inf, negative subnormal)     -> NO_REAL
//   - otherwise (incl. +inf, positive subnormal)  -> TWO_ROOTS
// - Push: disc_vld=1 and (count<DEPTH or pop this cycle). Entry is written on that
//   edge; out_vld rises the next cycle when the FIFO was empty (latency 1).
//   There is no same-cycle bypass.
// - Pop: out_vld & out_rdy. Head advances on that edge.
// - Push and pop in the same cycle: both happen and count is unchanged. This holds
//   when full, so no drop occurs.
// - Drop: disc_vld=1, count==DEPTH and no pop. Entry is discarded, overflow<=1, and
//   cnt_* are not incremented. Counters count accepted pushes only.
// - Pointers: log2(DEPTH) bits, wrap naturally. count is log2(DEPTH)+1 bits.
// - Counters saturate at all-ones and never wrap.
// - clr=1 zeroes overflow and cnt_* on the next edge. If it coincides with a push,
//   clr wins for the counters and the push still enters the FIFO. If it coincides
//   with a drop, overflow ends at 0.
// - Head data is stable while out_vld=1 and out_rdy=0.
// - Reset mid-operation: all contents are lost immediately and nothing is output.
// - disc_vld while rst=0 is ignored.
// STRUCTURE
// - Package float_root_class_pkg:
//   - typedef enum logic [1:0] root_class_t: NO_REAL=0, ONE_ROOT=1, TWO_ROOTS=2, ERR=3
//   - function classify(disc, err) implementing the priority table
//   - constants EXP_W=11, MANT_W=52
// - One sub-module: flop_fifo #(WIDTH, DEPTH), a register-array FIFO with
//   push/pop/full/empty and async active-low reset.
// - Top holds: the classifier call, drop/overflow logic and the four counters.
// TESTING
// - Single push of 4.0 (64'h4010_0000_0000_0000), out_rdy=1
//   -> out_vld high the next cycle, class=TWO_ROOTS, cnt_two=1.
// - Push each of: 64'h0, 64'h8000_0000_0000_0000, 64'hC000_0000_0000_0000,
//   64'h7FF8_0000_0000_0000, and 4.0 with disc_err=1
//   -> classes ONE, ONE, NO_REAL, ERR, ERR, in order.
// - out_rdy=0, push 5 values (DEPTH=4)
//   -> full=1 after the 4th, 5th dropped, overflow=1, cnt total=4, then drain gives the first 4 in order.
// - Full FIFO, push with out_rdy=1 in the same cycle
//   -> no drop, overflow stays 0, count stays 4, new entry appears last.
// - Back-to-back disc_vld every cycle with out_rdy=1
//   -> sustained 1 result/cycle, no overflow.
// - Assert rst=0 mid-stream with 3 entries queued
//   -> out_vld=0 asynchronously, counters 0; a push after release emerges first.

Source files
------------

// File: rtl/float_root_class_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_root_class_pkg
// Description : Shared types and helpers for the discriminant root classifier.
//               Defines the root class encoding, IEEE-754 double field widths
//               and the priority classifier function.
// Revision    : 1.0 - initial release
// ============================================================================
package float_root_class_pkg;

   localparam int EXP_W  = 11;
   localparam int MANT_W = 52;
   localparam int DBL_W  = EXP_W + MANT_W + 1;

   typedef enum logic [1:0] {
      NO_REAL   = 2'd0,
      ONE_ROOT  = 2'd1,
      TWO_ROOTS = 2'd2,
      ERR       = 2'd3
   } root_class_t;

   // Priority: upstream error, then NaN, then signed zero, then sign bit.
   // Infinities and subnormals fall through to the sign test on purpose.
   function automatic root_class_t classify(input logic [DBL_W-1:0] disc,
                                            input logic             err);
      logic [EXP_W-1:0]  exp_f;
      logic [MANT_W-1:0] mant_f;
      logic              sign_f;
      root_class_t       res;
      exp_f  = disc[DBL_W-2:MANT_W];
      mant_f = disc[MANT_W-1:0];
      sign_f = disc[DBL_W-1];
      if (err)                                res = ERR;
      else if ((&exp_f) && (|mant_f))         res = ERR;
      else if ((exp_f == '0) && (mant_f == '0)) res = ONE_ROOT;
      else if (sign_f)                        res = NO_REAL;
      else                                    res = TWO_ROOTS;
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/float_root_class_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : flop_fifo
// Description : Register-array FIFO with push/pop, full/empty flags.
//               A push while full is accepted only when a pop happens in the
//               same cycle; a pop while empty is ignored.
// Ports       : clk, rst_n (async active-low), push, pop, wdata -> rdata,
//               full, empty
// Revision    : 1.0 - initial release
// ============================================================================
module flop_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_BW = PTR_W + 1;
   localparam logic [CNT_BW-1:0] FULL_CNT = CNT_BW'(DEPTH);
   localparam logic [CNT_BW-1:0] CNT_ONE  = CNT_BW'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [WIDTH-1:0]  mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_BW-1:0] count_q, count_d;
   logic              do_push;
   logic              do_pop;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign rdata = mem_q[rd_ptr_q];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/float_root_class_buffer.sv
`default_nettype none
// ============================================================================
// Module      : float_root_class_buffer
// Description : Classifies discriminant results (no real / one / two roots /
//               error), buffers {disc, class} in a FIFO with a valid/ready
//               output, flags dropped results and keeps per-class counters.
// Ports       : clk, rst (async active-low)
//               disc_vld, disc, disc_err          - result strobe from upstream
//               out_vld, out_rdy, out_disc, out_class - FIFO head handshake
//               full, overflow (sticky), clr      - status / clear
//               cnt_none, cnt_one, cnt_two, cnt_err - saturating class counts
// Revision    : 1.0 - initial release
// ============================================================================
module float_root_class_buffer
   import float_root_class_pkg::*;
#(
   parameter int FLEN  = 64,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             disc_vld,
   input  logic [FLEN-1:0]  disc,
   input  logic             disc_err,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [FLEN-1:0]  out_disc,
   output logic [1:0]       out_class,
   output logic             full,
   output logic             overflow,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_none,
   output logic [CNT_W-1:0] cnt_one,
   output logic [CNT_W-1:0] cnt_two,
   output logic [CNT_W-1:0] cnt_err
);

   localparam int ENT_W = FLEN + 2;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   root_class_t      class_w;
   logic [1:0]       class_bits;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             push;
   logic             drop;
   logic [ENT_W-1:0] head;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];

   assign class_w    = classify(disc, disc_err);
   assign class_bits = class_w;

   assign out_vld = !fifo_empty;
   assign pop     = out_vld && out_rdy;
   // A simultaneous pop frees a slot, so a full FIFO still accepts the result.
   assign push    = disc_vld && (!fifo_full || pop);
   assign drop    = disc_vld && fifo_full && !pop;

   flop_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({disc, class_bits}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_disc  = head[ENT_W-1:2];
   assign out_class = head[1:0];
   assign full      = fifo_full;

   // Clear dominates both a coincident drop and coincident increments.
   always_comb begin
      overflow_d = overflow_q | drop;
      if (clr) overflow_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clr) begin
            cnt_d[i] = '0;
         end else if (push && (class_bits == 2'(i)) && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         overflow_q <= overflow_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign overflow = overflow_q;
   assign cnt_none = cnt_q[0];
   assign cnt_one  = cnt_q[1];
   assign cnt_two  = cnt_q[2];
   assign cnt_err  = cnt_q[3];

endmodule
`default_nettype wire
